// File: rtl/ram_1p_arbiter.sv
// Shares one synchronous single-port RAM between requesters A and B with
// round-robin arbitration, read-response routing and optional zero-fill after reset.
//
// state    | meaning
// ST_SCRUB | writing zero to every word, one per cycle; no grants
// ST_RUN   | arbitrating A/B every cycle
module ram_1p_arbiter #(
   parameter int Width = 32,
   parameter int Depth = 128,
   parameter bit ScrubOnReset = 1'b1,
   localparam int Aw = $clog2(Depth)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             a_req_i,
   output logic             a_gnt_o,
   input  logic             a_write_i,
   input  logic [Aw-1:0]    a_addr_i,
   input  logic [Width-1:0] a_wdata_i,
   input  logic [Width-1:0] a_wmask_i,
   output logic             a_rvalid_o,
   output logic [Width-1:0] a_rdata_o,
   output logic             a_rerror_o,
   input  logic             b_req_i,
   output logic             b_gnt_o,
   input  logic             b_write_i,
   input  logic [Aw-1:0]    b_addr_i,
   input  logic [Width-1:0] b_wdata_i,
   input  logic [Width-1:0] b_wmask_i,
   output logic             b_rvalid_o,
   output logic [Width-1:0] b_rdata_o,
   output logic             b_rerror_o,
   output logic             ram_req_o,
   output logic             ram_write_o,
   output logic [Aw-1:0]    ram_addr_o,
   output logic [Width-1:0] ram_wdata_o,
   output logic [Width-1:0] ram_wmask_o,
   input  logic [Width-1:0] ram_rdata_i,
   output logic             init_done_o
);

   typedef enum logic {ST_SCRUB, ST_RUN} state_e;

   localparam state_e        StReset  = ScrubOnReset ? ST_SCRUB : ST_RUN;
   localparam logic [Aw:0]   DepthW   = (Aw+1)'(Depth);
   localparam logic [Aw-1:0] LastAddr = Aw'(Depth - 1);

   state_e        state, state_nxt;
   logic [Aw-1:0] scrub_cnt, scrub_cnt_nxt;
   logic          prio_b, prio_b_nxt;
   logic          rsp_valid, rsp_valid_nxt;
   logic          rsp_owner_b, rsp_owner_b_nxt;
   logic          rsp_error, rsp_error_nxt;
   logic          sel_b;
   logic          addr_ok;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state       <= StReset;
         scrub_cnt   <= '0;
         prio_b      <= 1'b0;
         rsp_valid   <= 1'b0;
         rsp_owner_b <= 1'b0;
         rsp_error   <= 1'b0;
      end else begin
         state       <= state_nxt;
         scrub_cnt   <= scrub_cnt_nxt;
         prio_b      <= prio_b_nxt;
         rsp_valid   <= rsp_valid_nxt;
         rsp_owner_b <= rsp_owner_b_nxt;
         rsp_error   <= rsp_error_nxt;
      end
   end

   always_comb begin
      state_nxt       = state;
      scrub_cnt_nxt   = scrub_cnt;
      prio_b_nxt      = prio_b;
      rsp_valid_nxt   = 1'b0;
      rsp_owner_b_nxt = 1'b0;
      rsp_error_nxt   = 1'b0;
      a_gnt_o         = 1'b0;
      b_gnt_o         = 1'b0;
      sel_b           = 1'b0;
      addr_ok         = 1'b0;
      ram_req_o       = 1'b0;
      ram_write_o     = a_write_i;
      ram_addr_o      = a_addr_i;
      ram_wdata_o     = a_wdata_i;
      ram_wmask_o     = a_wmask_i;
      case (state)
         ST_SCRUB: begin
            ram_req_o     = 1'b1;
            ram_write_o   = 1'b1;
            ram_addr_o    = scrub_cnt;
            ram_wdata_o   = '0;
            ram_wmask_o   = '1;
            scrub_cnt_nxt = scrub_cnt + Aw'(1);
            if (scrub_cnt == LastAddr) begin
               state_nxt     = ST_RUN;
               scrub_cnt_nxt = '0;
            end
         end
         ST_RUN: begin
            // prio_b only matters when both request
            a_gnt_o     = a_req_i & (~b_req_i | ~prio_b);
            b_gnt_o     = b_req_i & (~a_req_i | prio_b);
            sel_b       = b_gnt_o;
            ram_write_o = sel_b ? b_write_i : a_write_i;
            ram_addr_o  = sel_b ? b_addr_i  : a_addr_i;
            ram_wdata_o = sel_b ? b_wdata_i : a_wdata_i;
            ram_wmask_o = sel_b ? b_wmask_i : a_wmask_i;
            addr_ok     = {1'b0, ram_addr_o} < DepthW;
            if (a_gnt_o | b_gnt_o) begin
               prio_b_nxt = a_gnt_o;
               ram_req_o  = addr_ok;
               if (!ram_write_o) begin
                  rsp_valid_nxt   = 1'b1;
                  rsp_owner_b_nxt = sel_b;
                  rsp_error_nxt   = ~addr_ok;
               end
            end
         end
         default: state_nxt = StReset;
      endcase
   end

   assign init_done_o = (state == ST_RUN);

   assign a_rvalid_o = rsp_valid & ~rsp_owner_b;
   assign b_rvalid_o = rsp_valid & rsp_owner_b;
   assign a_rerror_o = a_rvalid_o & rsp_error;
   assign b_rerror_o = b_rvalid_o & rsp_error;
   assign a_rdata_o  = (a_rvalid_o & ~rsp_error) ? ram_rdata_i : '0;
   assign b_rdata_o  = (b_rvalid_o & ~rsp_error) ? ram_rdata_i : '0;

endmodule

// File: tb/tb_ram_1p_arbiter.sv
// Bench for ram_1p_arbiter (Depth=6 so out-of-range addresses exist): directed
// scenarios with literal expectations plus random traffic against a memory model.
module tb_ram_1p_arbiter;
   localparam int W     = 32;
   localparam int DEPTH = 6;
   localparam int AW    = 3;

   logic          clk_i = 1'b0;
   logic          rst_ni = 1'b0;
   logic          a_req_i = 0, a_write_i = 0, b_req_i = 0, b_write_i = 0;
   logic [AW-1:0] a_addr_i = '0, b_addr_i = '0;
   logic [W-1:0]  a_wdata_i = '0, a_wmask_i = '0, b_wdata_i = '0, b_wmask_i = '0;
   logic          a_gnt_o, a_rvalid_o, a_rerror_o, b_gnt_o, b_rvalid_o, b_rerror_o;
   logic [W-1:0]  a_rdata_o, b_rdata_o;
   logic          ram_req_o, ram_write_o, init_done_o;
   logic [AW-1:0] ram_addr_o;
   logic [W-1:0]  ram_wdata_o, ram_wmask_o;
   logic [W-1:0]  ram_rdata = '0;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk_i = ~clk_i;

   ram_1p_arbiter #(.Width(W), .Depth(DEPTH), .ScrubOnReset(1'b1)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .a_req_i(a_req_i), .a_gnt_o(a_gnt_o), .a_write_i(a_write_i), .a_addr_i(a_addr_i),
      .a_wdata_i(a_wdata_i), .a_wmask_i(a_wmask_i), .a_rvalid_o(a_rvalid_o),
      .a_rdata_o(a_rdata_o), .a_rerror_o(a_rerror_o),
      .b_req_i(b_req_i), .b_gnt_o(b_gnt_o), .b_write_i(b_write_i), .b_addr_i(b_addr_i),
      .b_wdata_i(b_wdata_i), .b_wmask_i(b_wmask_i), .b_rvalid_o(b_rvalid_o),
      .b_rdata_o(b_rdata_o), .b_rerror_o(b_rerror_o),
      .ram_req_o(ram_req_o), .ram_write_o(ram_write_o), .ram_addr_o(ram_addr_o),
      .ram_wdata_o(ram_wdata_o), .ram_wmask_o(ram_wmask_o), .ram_rdata_i(ram_rdata),
      .init_done_o(init_done_o)
   );

   // RAM behaviour: preloaded with all ones, 1-cycle read, per-bit mask, data held otherwise
   logic [W-1:0] ram_mem [8];
   logic         ram_loaded = 1'b0;
   always @(posedge clk_i) begin
      if (!ram_loaded) begin
         for (int i = 0; i < 8; i++) ram_mem[i] <= 32'hFFFF_FFFF;
         ram_loaded <= 1'b1;
      end else if (ram_req_o) begin
         if (ram_write_o)
            ram_mem[ram_addr_o] <= (ram_mem[ram_addr_o] & ~ram_wmask_o) | (ram_wdata_o & ram_wmask_o);
         else
            ram_rdata <= ram_mem[ram_addr_o];
      end
   end

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: words written so far, cycles of zero-fill done, who has priority,
   // and the read response owed next cycle.
   logic [W-1:0] m_mem [DEPTH];
   int           m_scrubbed = 0;
   bit           m_prio_b = 0;
   bit           m_gnt_a = 0, m_gnt_b = 0;
   bit           m_pend = 0, m_pend_b = 0, m_pend_err = 0;
   logic [W-1:0] m_pend_data = '0;

   always @(negedge clk_i) begin
      bit ga, gb, wr, ok;
      int ad;
      logic [W-1:0] wd, wm;
      ga = 0; gb = 0;
      if (!rst_ni) begin
         m_scrubbed = 0; m_prio_b = 0; m_pend = 0;
         m_gnt_a = 0; m_gnt_b = 0;
         chk("rst_init_done", init_done_o, 0);
         chk("rst_a_gnt", a_gnt_o, 0);
         chk("rst_b_gnt", b_gnt_o, 0);
         chk("rst_a_rvalid", a_rvalid_o, 0);
         chk("rst_b_rvalid", b_rvalid_o, 0);
         chk("rst_a_rdata", a_rdata_o, 0);
         chk("rst_b_rdata", b_rdata_o, 0);
         chk("rst_a_rerror", a_rerror_o, 0);
         chk("rst_b_rerror", b_rerror_o, 0);
      end else begin
         chk("a_rvalid", a_rvalid_o, m_pend && !m_pend_b);
         chk("b_rvalid", b_rvalid_o, m_pend && m_pend_b);
         chk("a_rerror", a_rerror_o, m_pend && !m_pend_b && m_pend_err);
         chk("b_rerror", b_rerror_o, m_pend && m_pend_b && m_pend_err);
         if (m_pend && !m_pend_b) chk("a_rdata", a_rdata_o, m_pend_data);
         if (m_pend && m_pend_b)  chk("b_rdata", b_rdata_o, m_pend_data);
         m_pend = 0;
         if (m_scrubbed < DEPTH) begin
            chk("init_done", init_done_o, 0);
            chk("scrub_gnt", {a_gnt_o, b_gnt_o}, 0);
            chk("scrub_req", ram_req_o, 1);
            chk("scrub_write", ram_write_o, 1);
            chk("scrub_addr", ram_addr_o, m_scrubbed);
            chk("scrub_wdata", ram_wdata_o, 0);
            chk("scrub_wmask", ram_wmask_o, 32'hFFFF_FFFF);
            m_mem[m_scrubbed] = '0;
            m_scrubbed++;
         end else begin
            chk("init_done", init_done_o, 1);
            if (a_req_i && b_req_i) begin
               if (m_prio_b) gb = 1; else ga = 1;
            end else begin
               ga = a_req_i;
               gb = b_req_i;
            end
            chk("a_gnt", a_gnt_o, ga);
            chk("b_gnt", b_gnt_o, gb);
            wr = gb ? b_write_i : a_write_i;
            ad = gb ? int'(b_addr_i) : int'(a_addr_i);
            wd = gb ? b_wdata_i : a_wdata_i;
            wm = gb ? b_wmask_i : a_wmask_i;
            ok = ad < DEPTH;
            chk("ram_req", ram_req_o, (ga || gb) && ok);
            if ((ga || gb) && ok) begin
               chk("ram_write", ram_write_o, wr);
               chk("ram_addr", ram_addr_o, ad);
               if (wr) begin
                  chk("ram_wdata", ram_wdata_o, wd);
                  chk("ram_wmask", ram_wmask_o, wm);
               end
            end
            if (ga || gb) begin
               m_prio_b = ga;
               if (wr) begin
                  if (ok) m_mem[ad] = (m_mem[ad] & ~wm) | (wd & wm);
               end else begin
                  m_pend = 1;
                  m_pend_b = gb;
                  m_pend_err = !ok;
                  m_pend_data = ok ? m_mem[ad] : '0;
               end
            end
         end
         m_gnt_a = ga;
         m_gnt_b = gb;
      end
   end

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive_a(input logic req, input logic wr, input logic [AW-1:0] ad,
                          input logic [W-1:0] wd, input logic [W-1:0] wm);
      a_req_i = req; a_write_i = wr; a_addr_i = ad; a_wdata_i = wd; a_wmask_i = wm;
   endtask

   task automatic drive_b(input logic req, input logic wr, input logic [AW-1:0] ad,
                          input logic [W-1:0] wd, input logic [W-1:0] wm);
      b_req_i = req; b_write_i = wr; b_addr_i = ad; b_wdata_i = wd; b_wmask_i = wm;
   endtask

   initial begin
      // reset, with A already requesting a read of word 5 that must wait out the scrub
      drive_a(1, 0, 3'd5, '0, '0);
      repeat (3) step();
      @(negedge clk_i);
      chk("lit_reset_init_done", init_done_o, 0);
      chk("lit_reset_a_gnt", a_gnt_o, 0);
      step();
      rst_ni = 1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk_i);
         chk("lit_scrub1_addr", ram_addr_o, k);
         step();
      end
      rst_ni = 0;          // reset in cycle 3 of the scrub
      @(negedge clk_i);
      chk("lit_midscrub_rvalid", a_rvalid_o, 0);
      step();
      rst_ni = 1;
      for (int k = 0; k < DEPTH; k++) begin
         @(negedge clk_i);
         chk("lit_scrub2_addr", ram_addr_o, k);
         chk("lit_scrub2_gnt", a_gnt_o, 0);
         step();
      end
      @(negedge clk_i);
      chk("lit_init_done_at_depth", init_done_o, 1);
      chk("lit_first_gnt", a_gnt_o, 1);
      step();
      drive_a(0, 0, '0, '0, '0);
      @(negedge clk_i);
      chk("lit_scrubbed_rvalid", a_rvalid_o, 1);
      chk("lit_scrubbed_rdata", a_rdata_o, 32'h0);

      // single requester: write then read back
      step();
      drive_a(1, 1, 3'd3, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
      @(negedge clk_i);
      chk("lit_wr_gnt", a_gnt_o, 1);
      step();
      drive_a(1, 0, 3'd3, '0, '0);
      @(negedge clk_i);
      chk("lit_rd_gnt", a_gnt_o, 1);
      chk("lit_wr_no_rvalid", a_rvalid_o, 0);
      step();
      drive_a(0, 0, '0, '0, '0);
      @(negedge clk_i);
      chk("lit_rd_rvalid", a_rvalid_o, 1);
      chk("lit_rd_rdata", a_rdata_o, 32'hDEAD_BEEF);
      chk("lit_rd_b_rvalid", b_rvalid_o, 0);

      // masked write
      step();
      drive_a(1, 1, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      step();
      drive_a(1, 1, 3'd1, 32'h0000_0000, 32'h0000_FFFF);
      step();
      drive_a(1, 0, 3'd1, '0, '0);
      step();
      drive_a(0, 0, '0, '0, '0);
      @(negedge clk_i);
      chk("lit_mask_rdata", a_rdata_o, 32'hFFFF_0000);

      // contention after a fresh reset: B writes last so priority is back at A
      step();
      rst_ni = 0;
      step();
      rst_ni = 1;
      repeat (DEPTH) step();
      drive_a(1, 1, 3'd2, 32'h0000_0022, 32'hFFFF_FFFF);
      step();
      drive_a(0, 0, '0, '0, '0);
      drive_b(1, 1, 3'd4, 32'h0000_0044, 32'hFFFF_FFFF);
      step();
      drive_a(1, 0, 3'd2, '0, '0);
      drive_b(1, 0, 3'd4, '0, '0);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk_i);
         chk("lit_rr_a_gnt", a_gnt_o, (k % 2) == 0);
         chk("lit_rr_b_gnt", b_gnt_o, (k % 2) == 1);
         if (k > 0) begin
            if (k % 2 == 1) chk("lit_rr_a_rdata", a_rdata_o, 32'h22);
            else            chk("lit_rr_b_rdata", b_rdata_o, 32'h44);
         end
         step();
      end
      drive_a(0, 0, '0, '0, '0);
      drive_b(0, 0, '0, '0, '0);
      @(negedge clk_i);
      chk("lit_rr_last_b_rvalid", b_rvalid_o, 1);
      chk("lit_rr_last_b_rdata", b_rdata_o, 32'h44);

      // out-of-range read
      step();
      drive_b(1, 0, 3'd7, '0, '0);
      @(negedge clk_i);
      chk("lit_oor_gnt", b_gnt_o, 1);
      chk("lit_oor_ram_req", ram_req_o, 0);
      step();
      drive_b(0, 0, '0, '0, '0);
      @(negedge clk_i);
      chk("lit_oor_rvalid", b_rvalid_o, 1);
      chk("lit_oor_rerror", b_rerror_o, 1);
      chk("lit_oor_rdata", b_rdata_o, 0);

      // random traffic; payload held until the model says it was granted
      for (int n = 0; n < 3000; n++) begin
         step();
         if (!rst_ni) rst_ni = 1;
         else if ($urandom_range(0, 399) == 0) rst_ni = 0;
         if (!a_req_i || m_gnt_a)
            drive_a($urandom_range(0, 99) < 60, $urandom_range(0, 2) == 0,
                    AW'($urandom_range(0, 7)), $urandom,
                    ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : $urandom);
         if (!b_req_i || m_gnt_b)
            drive_b($urandom_range(0, 99) < 60, $urandom_range(0, 2) == 0,
                    AW'($urandom_range(0, 7)), $urandom,
                    ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : $urandom);
      end
      step();
      rst_ni = 1;
      drive_a(0, 0, '0, '0, '0);
      drive_b(0, 0, '0, '0, '0);
      repeat (3) step();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/ram_1p_arbiter.md
# ram_1p_arbiter

Two-requester arbiter and initialisation sequencer in front of a single synchronous single-port RAM (1-cycle read latency, per-bit write mask, read data held when not reading). It shares the one RAM port between requesters A and B with req/gnt handshakes and round-robin fairness. It routes each read response back to its issuer. After reset it can zero-fill the whole RAM before granting any access.

## Interface
Parameters:
- Width, 32, data width in bits.
- Depth, 128, number of RAM words.
- ScrubOnReset, 1, 1 = zero-fill all words after reset before granting; 0 = grant immediately.
- Aw, $clog2(Depth), derived address width (localparam).

Ports (x ∈ {a, b}):
- clk_i  in  1  clock, all logic on rising edge.
- rst_ni  in  1  reset, asynchronous assert, active-low.
- x_req_i  in  1  access request; held with payload stable until granted.
- x_gnt_o  out  1  request accepted this cycle (combinational from req and arbiter state).
- x_write_i  in  1  1 = write, 0 = read.
- x_addr_i  in  Aw  word address.
- x_wdata_i  in  Width  write data.
- x_wmask_i  in  Width  per-bit write enable.
- x_rvalid_o  out  1  read response valid; one cycle after that requester's read grant.
- x_rdata_o  out  Width  read data; meaningful only while x_rvalid_o = 1.
- x_rerror_o  out  1  with x_rvalid_o: the granted read address was ≥ Depth.
- ram_req_o, ram_write_o  out  1  RAM request / write.
- ram_addr_o  out  Aw  RAM address.
- ram_wdata_o, ram_wmask_o  out  Width  RAM write data / mask.
- ram_rdata_i  in  Width  RAM read data, valid one cycle after a read request.
- init_done_o  out  1  scrub complete; arbitration enabled.

## Operation
- FSM states:
  - SCRUB:
    - ram_req_o = 1, ram_write_o = 1, ram_wmask_o = all ones, ram_wdata_o = 0, ram_addr_o = scrub counter.
    - The counter runs 0 … Depth-1, one write per cycle.
    - After the write to Depth-1, go to RUN.
    - All gnt_o = 0 in SCRUB.
  - RUN: arbitrate every cycle.
- Reset state is SCRUB if ScrubOnReset = 1, else RUN.
- Arbitration in RUN:
  - If exactly one requester asserts req, it is granted.
  - If both assert req, the requester named by the priority pointer is granted.
  - Priority pointer resets to A.
  - On any grant the pointer moves to the requester not granted. With both requesting, grants therefore alternate A, B, A, B.
  - At most one gnt_o is high per cycle.
- RAM drive in RUN: ram_* mirror the granted requester's write, addr, wdata, wmask. ram_req_o = 1 only if a grant is issued and addr < Depth.
- Out-of-range address (addr ≥ Depth, possible only when Depth is not a power of two):
  - The request is still granted, but ram_req_o = 0.
  - A write is dropped silently.
  - A read returns rvalid with rerror = 1 and rdata = 0.
- Response routing:
  - A one-entry response register holds {valid, owner, error}.
  - It is loaded on every read grant and cleared otherwise.
  - x_rvalid_o = valid and owner = x.
  - x_rdata_o = ram_rdata_i when owner = x and error = 0, else 0.
- Writes produce no response.

## Timing
- Reset values: all gnt_o = 0, rvalid_o = 0, rerror_o = 0, rdata_o = 0.
  - init_done_o = 0 if ScrubOnReset, else 1.
  - Scrub counter = 0; response register invalid.
- Scrub takes exactly Depth cycles after reset release. init_done_o rises in the cycle RUN is entered, and the first grant is possible in that same cycle.
- Grant latency is 0 cycles: gnt is combinational in the same cycle as req when the requester wins.
- Read latency is 1 cycle: rvalid in the cycle after gnt.
- Back-to-back reads by the same or alternating requesters are sustained at one per cycle. Each response is tagged to its own issuer.
- A write granted in cycle N followed by a read of the same address granted in cycle N+1 returns the new data in cycle N+2.
- Reset asserted mid-scrub or mid-read:
  - All state returns to reset values immediately (asynchronous).
  - The pending response is dropped; no rvalid is emitted after reset.
  - The scrub restarts from 0.
- Requests held during SCRUB are not granted and are not lost; they are granted in RUN per the arbitration rules.

## Test plan
- Scrub: Depth=8, ScrubOnReset=1, RAM preloaded with 0xFFFFFFFF.
  - Expect writes to addresses 0…7 in cycles 0…7 and init_done_o = 1 at cycle 8.
  - A read of address 5 by A afterwards returns 0.
- Single requester: A writes 0xDEADBEEF to address 3 (mask all ones), then reads address 3 on the next cycle.
  - Expect gnt the same cycle each time, and a_rvalid with 0xDEADBEEF one cycle after the read grant.
  - b_rvalid stays 0.
- Contention: A and B both hold req for 6 cycles after reset, both reads.
  - Expect grants A, B, A, B, A, B.
  - Expect rvalid alternating between the two requesters, each returning its own address's data.
- Masked write: write 0xFFFFFFFF to address 1, then write 0x00000000 with mask 0x0000FFFF.
  - A read of address 1 returns 0xFFFF0000.
- Out-of-range: Depth=6, B reads address 7.
  - Expect gnt, ram_req_o = 0, and next cycle b_rvalid = 1, b_rerror = 1, b_rdata = 0.
- Reset mid-scrub at cycle 3, then release.
  - Expect the scrub to restart at address 0, no grants until Depth cycles later, and no spurious rvalid.
